// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter and related shared-buffer logic.
package mem_arb_pkg;

  localparam int ADDR_W        = 10;
  localparam int DATA_W        = 32;
  localparam int MAX_BURST_DEF = 4;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    P0   = 2'b01,
    P1   = 2'b10
  } owner_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: on a tie the port that was not served last wins.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt0,
  output logic gnt1
);

  assign gnt0 = req0 & (~req1 | last);
  assign gnt1 = req1 & (~req0 | ~last);

endmodule

// File: rtl/datamemory_arbiter.sv
// Shares the single-port data memory between the CPU (port 0) and the CNN loader (port 1),
// with round-robin arbitration, bounded burst locking and registered read return.
module datamemory_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              grant0,
  output logic              grant1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_memread,
  output logic              mem_memwrite,
  input  logic [DATA_W-1:0] mem_readdata
);

  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  owner_t      owner_reg, owner_next;
  logic [3:0]  burst_cnt_reg, burst_cnt_next;
  logic        last_reg, last_next;
  logic        locked0, locked1;
  logic        pick0, pick1;
  logic        g_we, g_lock;
  owner_t      g_owner;

  rr_pick2 u_pick (
    .req0 (req0),
    .req1 (req1),
    .last (last_reg),
    .gnt0 (pick0),
    .gnt1 (pick1)
  );

  // A held lock wins only until the burst limit is reached while the other port waits.
  always_comb begin
    locked0 = (owner_reg == P0) && req0 && ((burst_cnt_reg < BURST_LAST) || !req1);
    locked1 = (owner_reg == P1) && req1 && ((burst_cnt_reg < BURST_LAST) || !req0);
    grant0  = locked0 | (~locked1 & pick0);
    grant1  = locked1 | (~locked0 & pick1);
  end

  always_comb begin
    mem_address   = '0;
    mem_writedata = '0;
    mem_memread   = 1'b0;
    mem_memwrite  = 1'b0;
    g_we          = 1'b0;
    g_lock        = 1'b0;
    g_owner       = NONE;
    if (grant0) begin
      mem_address   = addr0;
      mem_writedata = wdata0;
      g_we          = we0;
      g_lock        = lock0;
      g_owner       = P0;
    end else if (grant1) begin
      mem_address   = addr1;
      mem_writedata = wdata1;
      g_we          = we1;
      g_lock        = lock1;
      g_owner       = P1;
    end
    if (grant0 || grant1) begin
      mem_memwrite = g_we;
      mem_memread  = ~g_we;
    end
  end

  always_comb begin
    owner_next     = NONE;
    burst_cnt_next = 4'd0;
    last_next      = last_reg;
    if (grant0 || grant1) begin
      last_next = grant1;
      if (g_lock) begin
        owner_next = g_owner;
        if (owner_reg == g_owner)
          burst_cnt_next = (burst_cnt_reg >= BURST_LAST) ? BURST_LAST : burst_cnt_reg + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_reg     <= NONE;
      burst_cnt_reg <= 4'd0;
      last_reg      <= 1'b1;
      rvalid0       <= 1'b0;
      rvalid1       <= 1'b0;
      rdata0        <= '0;
      rdata1        <= '0;
    end else begin
      owner_reg     <= owner_next;
      burst_cnt_reg <= burst_cnt_next;
      last_reg      <= last_next;
      rvalid0       <= grant0 & ~we0;
      rvalid1       <= grant1 & ~we1;
      if (grant0 && !we0)
        rdata0 <= mem_readdata;
      if (grant1 && !we1)
        rdata1 <= mem_readdata;
    end
  end

endmodule

// File: tb/tb_datamemory_arbiter.sv
// Directed bench for datamemory_arbiter with a behavioural single-port memory model.
module tb_datamemory_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1, lock0, lock1;
  logic [9:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        grant0, grant1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic [9:0]  mem_address;
  logic [31:0] mem_writedata, mem_readdata;
  logic        mem_memread, mem_memwrite;

  logic [31:0] mem [0:1023];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_memwrite) mem[mem_address] <= mem_writedata;
  assign mem_readdata = mem_memread ? mem[mem_address] : 32'h0;

  datamemory_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .grant0(grant0), .grant1(grant1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_readdata(mem_readdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
      $error("check %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[10'h001] = 32'h1111_1111;
    mem[10'h145] = 32'h2222_2222;
    idle();
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 0;
    #1;
    check("rst_rvalid0", {31'b0, rvalid0}, 32'd0);
    check("rst_rvalid1", {31'b0, rvalid1}, 32'd0);
    check("rst_rdata0", rdata0, 32'h0);
    check("rst_rdata1", rdata1, 32'h0);
    check("idle_grants", {30'b0, grant1, grant0}, 32'd0);
    check("idle_mem", {mem_memread, mem_memwrite, 20'b0, mem_address}, 32'd0);
    $display("txn reset done");

    // Single port write then read back
    @(negedge clk);
    req0 = 1; we0 = 1; addr0 = 10'h000; wdata0 = 32'hC00000F0;
    #1;
    check("wr_grant0", {30'b0, grant1, grant0}, 32'd1);
    check("wr_memwrite", {30'b0, mem_memwrite, mem_memread}, 32'd2);
    check("wr_wdata", mem_writedata, 32'hC00000F0);
    $display("txn write p0 addr=000 data=C00000F0");
    @(posedge clk); #1;
    check("wr_no_rvalid", {30'b0, rvalid1, rvalid0}, 32'd0);
    @(negedge clk);
    we0 = 0;
    #1;
    check("rd_memread", {30'b0, mem_memwrite, mem_memread}, 32'd1);
    @(posedge clk); #1;
    check("rd_rvalid0", {30'b0, rvalid1, rvalid0}, 32'd1);
    check("rd_rdata0", rdata0, 32'hC00000F0);
    $display("txn read p0 addr=000 rdata=%h", rdata0);

    // Tie after reset: port 0 first, port 1 next
    @(negedge clk); idle(); reset = 1;
    @(negedge clk); reset = 0;
    req0 = 1; addr0 = 10'h001; req1 = 1; addr1 = 10'h145;
    #1;
    check("tie_grant0", {30'b0, grant1, grant0}, 32'd1);
    check("tie_addr0", {22'b0, mem_address}, 32'h001);
    @(posedge clk); #1;
    check("tie_rvalid0", {30'b0, rvalid1, rvalid0}, 32'd1);
    check("tie_rdata0", rdata0, 32'h1111_1111);
    @(negedge clk); req0 = 0;
    #1;
    check("tie_grant1", {30'b0, grant1, grant0}, 32'd2);
    check("tie_addr1", {22'b0, mem_address}, 32'h145);
    @(posedge clk); #1;
    check("tie_rvalid1", {30'b0, rvalid1, rvalid0}, 32'd2);
    check("tie_rdata1", rdata1, 32'h2222_2222);
    $display("txn tie rdata0=%h rdata1=%h", rdata0, rdata1);

    // Steady contention without locks alternates, starting with port 0
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      req0 = 1; req1 = 1; addr0 = 10'h001; addr1 = 10'h145;
      #1;
      check("rr_alt", {30'b0, grant1, grant0}, (i % 2 == 0) ? 32'd1 : 32'd2);
      $display("txn contention cycle=%0d grant0=%0b grant1=%0b", i, grant0, grant1);
    end

    // Locked burst by port 1 under contention: 4 grants, then port 0
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      req1 = 1; lock1 = 1; req0 = (c >= 2);
      #1;
      check("burst_grant", {30'b0, grant1, grant0}, (c <= 4) ? 32'd2 : 32'd1);
      $display("txn burst cycle=%0d grant0=%0b grant1=%0b", c, grant0, grant1);
    end

    // Lock without contention: unbounded, counter saturates
    @(negedge clk); idle();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      req0 = 1; lock0 = 1; addr0 = 10'(c);
      #1;
      check("nolimit_grant", {30'b0, grant1, grant0}, 32'd1);
      check("nolimit_mem", {mem_memread, mem_memwrite, 20'b0, mem_address}, {2'b10, 20'b0, 10'(c)});
      $display("txn solo lock cycle=%0d grant0=%0b", c, grant0);
    end
    @(posedge clk); #1;
    check("sat_cnt", {28'b0, dut.burst_cnt_reg}, 32'd3);
    @(negedge clk);
    req1 = 1;
    #1;
    check("forced_release", {30'b0, grant1, grant0}, 32'd2);
    $display("txn forced release grant1=%0b", grant1);

    // Reset mid-burst with a read pending
    @(negedge clk); idle();
    req1 = 1; lock1 = 1; addr1 = 10'h145;
    #1;
    check("mid_b1", {30'b0, grant1, grant0}, 32'd2);
    @(negedge clk);
    reset = 1;
    #1;
    check("mid_b2", {30'b0, grant1, grant0}, 32'd2);
    @(posedge clk); #1;
    check("mid_rvalid", {30'b0, rvalid1, rvalid0}, 32'd0);
    @(negedge clk);
    reset = 0; req0 = 1; addr0 = 10'h001;
    #1;
    check("post_rst_tie", {30'b0, grant1, grant0}, 32'd1);
    $display("txn reset mid-burst grant0=%0b grant1=%0b", grant0, grant1);

    @(negedge clk); idle();
    #1;
    check("end_idle_mem", {mem_memread, mem_memwrite, 20'b0, mem_address}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
